// File: rtl/aes_pkg.sv
// Shared types and helpers for the ShiftRows engine.
package aes_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Left-rotate amount for a row; wide (NB=8) states skip amount 2.
  function automatic int shift_amt(input int nb, input int row);
    int amt;
    amt = row;
    if (nb == 8 && row >= 2) amt = row + 1;
    return amt;
  endfunction

endpackage

// File: rtl/row_rotator.sv
// Combinational rotate of one NB-byte state row, forward or inverse.
module row_rotator
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [BYTE_W*NB-1:0] row,
  input  logic [1:0]           row_idx,
  input  logic                 inv,
  output logic [BYTE_W*NB-1:0] rotated
);

  always_comb begin
    int s;
    int src;
    rotated = '0;
    s = shift_amt(NB, int'(row_idx));
    for (int c = 0; c < NB; c++) begin
      src = inv ? (c - s + NB) % NB : (c + s) % NB;
      rotated[BYTE_W*(NB-1-c) +: BYTE_W] =
        row[BYTE_W*(NB-1-src) +: BYTE_W];
    end
  end

endmodule

// File: rtl/shift_rows_engine.sv
// Sequential (Inv)ShiftRows, one row per clock through a shared rotator.
// Define SHIFT_ROWS_ENGINE_PERF_CNT_EN to add the done_cnt output.
module shift_rows_engine
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            inv,
  input  logic [32*NB-1:0] state_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] state_out,
  output logic            busy
`ifdef SHIFT_ROWS_ENGINE_PERF_CNT_EN
  ,
  output logic [31:0]     done_cnt
`endif
);

  localparam int SW = 32*NB;
  localparam int RW = BYTE_W*NB;

  fsm_t          st;
  logic [1:0]    row_cnt;
  logic          inv_q;
  logic [SW-1:0] sr;
  logic [SW-1:0] sr_nxt;
  logic [RW-1:0] row_cur;
  logic [RW-1:0] row_rot;

  // Row r gathers bytes r, r+4, r+8, ... of the column-major state.
  always_comb begin
    row_cur = '0;
    for (int c = 0; c < NB; c++) begin
      row_cur[BYTE_W*(NB-1-c) +: BYTE_W] =
        sr[SW-1-BYTE_W*(int'(row_cnt)+4*c) -: BYTE_W];
    end
  end

  row_rotator #(
    .NB(NB)
  ) u_rot (
    .row     (row_cur),
    .row_idx (row_cnt),
    .inv     (inv_q),
    .rotated (row_rot)
  );

  always_comb begin
    sr_nxt = sr;
    for (int c = 0; c < NB; c++) begin
      sr_nxt[SW-1-BYTE_W*(int'(row_cnt)+4*c) -: BYTE_W] =
        row_rot[BYTE_W*(NB-1-c) +: BYTE_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      row_cnt <= 2'd0;
      inv_q   <= 1'b0;
      sr      <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            sr      <= state_in;
            inv_q   <= inv;
            row_cnt <= 2'd0;
            st      <= ROT;
          end
        end
        ROT: begin
          sr      <= sr_nxt;
          row_cnt <= row_cnt + 2'd1;
          if (row_cnt == 2'd3) st <= DONE;
        end
        DONE: begin
          if (out_ready) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign in_ready  = (st == IDLE);
  assign busy      = (st == ROT);
  assign out_valid = (st == DONE);
  assign state_out = sr;

`ifdef SHIFT_ROWS_ENGINE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= 32'd0;
    end else if (st == DONE && out_ready) begin
      done_cnt <= done_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_rows_engine.sv
// Drives NB=4 and NB=8 engines in lockstep and checks them against a byte-array model.
module tb_shift_rows_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, inv, out_ready;
  logic [127:0] si4, so4;
  logic [255:0] si8, so8;
  logic ir4, ov4, b4, ir8, ov8, b8;
`ifdef SHIFT_ROWS_ENGINE_PERF_CNT_EN
  logic [31:0] dc4, dc8;
`endif

  int n_chk = 0;
  int n_fail = 0;

  shift_rows_engine #(.NB(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
    .inv(inv), .state_in(si4), .out_valid(ov4), .out_ready(out_ready),
    .state_out(so4), .busy(b4)
`ifdef SHIFT_ROWS_ENGINE_PERF_CNT_EN
    , .done_cnt(dc4)
`endif
  );

  shift_rows_engine #(.NB(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
    .inv(inv), .state_in(si8), .out_valid(ov8), .out_ready(out_ready),
    .state_out(so8), .busy(b8)
`ifdef SHIFT_ROWS_ENGINE_PERF_CNT_EN
    , .done_cnt(dc8)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ref_sr(input logic [255:0] x,
                                          input int nb, input bit iv);
    logic [7:0] b [32];
    logic [255:0] y;
    int sh [4];
    int sw, src;
    sw = 32*nb;
    y = '0;
    if (nb == 8) sh = '{0, 1, 3, 4};
    else         sh = '{0, 1, 2, 3};
    for (int i = 0; i < 4*nb; i++) b[i] = x[sw-1-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        src = iv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
        y[sw-1-8*(r+4*c) -: 8] = b[r + 4*src];
      end
    return y;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom())};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_both(input string tag, input logic [255:0] d,
                          input bit iv);
    chk({tag, "/out4"}, {128'd0, so4}, ref_sr({128'd0, d[127:0]}, 4, iv));
    chk({tag, "/out8"}, so8, ref_sr(d, 8, iv));
  endtask

  task automatic run(input string tag, input logic [255:0] d, input bit iv);
    int lat, w;
    w = 0;
    while (!(ir4 && ir8) && w < 20) begin step(); w++; end
    chk({tag, "/ready"}, {ir4, ir8}, 2'b11);
    si4 = d[127:0];
    si8 = d;
    inv = iv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    inv = ~iv;
    chk({tag, "/accept"}, {b4, b8, ir4, ir8, ov4, ov8}, 6'b110000);
    lat = 0;
    while (!ov4 && lat < 20) begin step(); lat++; end
    chk({tag, "/latency"}, lat, 4);
    chk({tag, "/done8"}, {ov8, b8, ir8}, 3'b100);
    chk_both(tag, d, iv);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "/drain"}, {ir4, ir8, ov4, ov8}, 4'b1100);
  endtask

  initial begin
    logic [255:0] d, r, hold8;
    logic [127:0] hold4;
    logic [63:0] row3;
    bit iv;
    rst = 1'b1;
    in_valid = 1'b0;
    inv = 1'b0;
    out_ready = 1'b0;
    si4 = '0;
    si8 = '0;
    step();
    step();
    chk("reset_ctl", {ir4, ov4, b4, ir8, ov8, b8}, 6'b100100);
    chk("reset_out4", so4, 0);
    chk("reset_out8", so8, 0);
    rst = 1'b0;
    step();

    d = rnd256();
    d[127:0] = 128'hd42711aee0bf98f1b8b45de51e415230;
    run("fips_fwd", d, 1'b0);
    chk("fips_fwd_vec", so4, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    drain("fips_fwd");

    d = rnd256();
    d[127:0] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    run("fips_inv", d, 1'b1);
    chk("fips_inv_vec", so4, 128'hd42711aee0bf98f1b8b45de51e415230);
    drain("fips_inv");

    for (int i = 0; i < 32; i++) d[255-8*i -: 8] = 8'(i);
    run("nb8_fwd", d, 1'b0);
    for (int c = 0; c < 8; c++) row3[63-8*c -: 8] = so8[255-8*(3+4*c) -: 8];
    chk("nb8_row3", row3, 64'h13171b1f03070b0f);
    chk("nb8_row2c0", so8[239 -: 8], 8'h0e);
    r = so8;
    drain("nb8_fwd");
    run("nb8_inv", r, 1'b1);
    chk("nb8_roundtrip", so8, d);
    drain("nb8_inv");

    d = rnd256();
    run("bp", d, 1'b1);
    hold4 = so4;
    hold8 = so8;
    in_valid = 1'b1;
    si4 = ~si4;
    si8 = ~si8;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_ctl", {ov4, ov8, ir4, ir8, b4, b8}, 6'b110000);
      chk("bp_hold4", so4, hold4);
      chk("bp_hold8", so8, hold8);
    end
    in_valid = 1'b0;
    drain("bp");

    d = rnd256();
    si4 = d[127:0];
    si8 = d;
    inv = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("mid_busy", {b4, b8}, 2'b11);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {ov4, ov8, ir4, ir8, b4, b8}, 6'b001100);
    chk("mid_rst_out4", so4, 0);
    chk("mid_rst_out8", so8, 0);
    step();
    rst = 1'b0;
    step();
    d = rnd256();
    run("post_rst", d, 1'($urandom_range(0, 1)));
    drain("post_rst");

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d = rnd256();
      iv = 1'($urandom_range(0, 1));
      si4 = d[127:0];
      si8 = d;
      inv = iv;
      step();
      chk("b2b_accept", {b4, b8, ir4, ir8}, 4'b1100);
      inv = ~iv;
      repeat (3) step();
      chk("b2b_rot", {ov4, ov8}, 2'b00);
      step();
      chk("b2b_done", {ov4, ov8}, 2'b11);
      chk_both("b2b", d, iv);
      step();
      chk("b2b_idle", {ir4, ir8, ov4, ov8}, 4'b1100);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
`ifdef SHIFT_ROWS_ENGINE_PERF_CNT_EN
    chk("done_cnt4", dc4, 5);
    chk("done_cnt8", dc8, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
